// File: rtl/rcond_pkg.sv
// Shared definitions for the roll button conditioner.
//   - 3-bit state encoding constants for the conditioning FSM
//   - default debounce, minimum-roll and long-press cycle counts
//   - helper that tells whether a state drives the roll output high
package rcond_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] DB_PRESS   = 3'd1;
  localparam logic [STATE_W-1:0] ROLLING    = 3'd2;
  localparam logic [STATE_W-1:0] DB_RELEASE = 3'd3;
  localparam logic [STATE_W-1:0] MIN_HOLD   = 3'd4;

  localparam int DEF_DEBOUNCE_CYCLES   = 4;
  localparam int DEF_MIN_ROLL_CYCLES   = 6;
  localparam int DEF_LONG_PRESS_CYCLES = 16;
  localparam int DEF_CNT_W             = 8;

  // The dice keep shuffling in every state past the press debounce.
  function automatic logic is_roll_state(input logic [STATE_W-1:0] st);
    return (st == ROLLING) || (st == DB_RELEASE) || (st == MIN_HOLD);
  endfunction

endpackage

// File: rtl/roll_button_conditioner_sync.sv
// Two-flop synchroniser for the raw push-button.
//   clk  in  system clock
//   rst  in  synchronous active-high reset, clears both flops
//   d    in  asynchronous input
//   q    out synchronised copy of d, two clocks later
module button_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/roll_button_conditioner.sv
// Conditions the raw dice push-button before it reaches the dice counter.
// Synchronises and debounces the button, stretches short taps to a minimum
// roll length, and emits single-cycle press / release / long-press events.
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   button      in   raw asynchronous push-button, active-high
//   roll        out  registered debounced roll level (feeds the dice)
//   pressed     out  one-cycle pulse in the cycle roll rises
//   released    out  one-cycle pulse in the cycle roll falls
//   long_press  out  one-cycle pulse, at most once per roll
//   busy        out  high whenever the FSM is not idle
module roll_button_conditioner
  import rcond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_ROLL_CYCLES   = DEF_MIN_ROLL_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic roll,
  output logic pressed,
  output logic released,
  output logic long_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] D_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] M_LAST   = CNT_W'(MIN_ROLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HCNT_MAX = '1;

  logic               sbtn;
  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   dcnt;
  logic [CNT_W-1:0]   hcnt;
  logic [CNT_W-1:0]   hcnt_inc;
  logic               lp_done;
  logic               in_roll;
  logic               lp_hit;

  button_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button),
    .q   (sbtn)
  );

  // Hold counter saturates so a very long hold never re-arms long_press.
  assign hcnt_inc = (hcnt == HCNT_MAX) ? hcnt : hcnt + 1'b1;
  assign in_roll  = is_roll_state(state);
  assign lp_hit   = in_roll && (hcnt == L_LAST) && !lp_done;
  assign busy     = (state != IDLE);

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dcnt       <= '0;
      hcnt       <= '0;
      lp_done    <= 1'b0;
      roll       <= 1'b0;
      pressed    <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
    end else begin
      // roll lags the state register by one cycle; the edge pulses are
      // taken from the same transition so they line up with roll.
      roll       <= in_roll;
      pressed    <= in_roll & ~roll;
      released   <= ~in_roll & roll;
      long_press <= lp_hit;
      if (lp_hit) lp_done <= 1'b1;

      // NOTE: the default arm recovers from unused encodings; all paths that
      // do not assign a register simply hold it, so no latch can arise here.
      case (state)
        IDLE: begin
          lp_done <= 1'b0;
          if (sbtn) begin
            state <= DB_PRESS;
            dcnt  <= '0;
          end
        end
        DB_PRESS: begin
          if (!sbtn) begin
            state <= IDLE;                 // glitch: no pulse, no roll
          end else if (dcnt == D_LAST) begin
            state <= ROLLING;
            hcnt  <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ROLLING: begin
          hcnt <= hcnt_inc;
          if (!sbtn) begin
            state <= DB_RELEASE;
            dcnt  <= '0;
          end
        end
        DB_RELEASE: begin
          hcnt <= hcnt_inc;
          if (sbtn) begin
            state <= ROLLING;              // bounce: hold time is kept
          end else if (dcnt == D_LAST) begin
            state <= (hcnt >= M_LAST) ? IDLE : MIN_HOLD;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        MIN_HOLD: begin
          // Button is ignored here so a tap always gives a full shuffle.
          hcnt <= hcnt_inc;
          if (hcnt >= M_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roll_button_conditioner.sv
// Directed self-checking bench for roll_button_conditioner (default parameters).
// Edge numbering in comments: "edge 0" is the first rising edge that samples
// the new button level; outputs are sampled 1 ns after each rising edge.
module tb_roll_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic button;
  logic roll, pressed, released, long_press, busy;

  int tests = 0;
  int fails = 0;

  // Pulse counters sampled on the falling edge, away from the active edge.
  int n_pressed = 0, n_released = 0, n_long = 0;
  int b_pressed, b_released, b_long;

  // Behavioural dice fed by roll: 1..6, advances on each edge roll is high.
  logic       dice_rst;
  logic [2:0] dice;

  roll_button_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .roll       (roll),
    .pressed    (pressed),
    .released   (released),
    .long_press (long_press),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pressed)    n_pressed  <= n_pressed + 1;
    if (released)   n_released <= n_released + 1;
    if (long_press) n_long     <= n_long + 1;
  end

  always @(posedge clk) begin
    if (dice_rst)  dice <= 3'd1;
    else if (roll) dice <= (dice == 3'd6) ? 3'd1 : dice + 3'd1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_pressed  = n_pressed;
    b_released = n_released;
    b_long     = n_long;
  endtask

  initial begin
    rst      = 1'b1;
    button   = 1'b0;
    dice_rst = 1'b1;
    step(2);
    check("reset_roll", roll, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {pressed, released, long_press}, 0);
    rst = 1'b0;
    step(3);
    check("idle_busy", busy, 0);

    // 1. Clean press held for 40 samples (edges 0..39).
    snap();
    button = 1'b1;
    step(7);                                   // after edge 6
    check("t1_roll_pre", roll, 0);
    check("t1_busy_pre", busy, 1);
    step(1);                                   // after edge 7
    check("t1_roll", roll, 1);
    check("t1_pressed", pressed, 1);
    step(1);
    check("t1_pressed_off", pressed, 0);
    step(13);                                  // after edge 21
    check("t1_long_early", long_press, 0);
    step(1);                                   // after edge 22
    check("t1_long", long_press, 1);
    step(1);
    check("t1_long_off", long_press, 0);
    step(16);                                  // after edge 39
    button = 1'b0;
    step(7);                                   // after edge 46
    check("t1_roll_hold", roll, 1);
    step(1);                                   // after edge 47
    check("t1_roll_fall", roll, 0);
    check("t1_released", released, 1);
    step(1);
    check("t1_long_count", n_long - b_long, 1);
    check("t1_press_count", n_pressed - b_pressed, 1);
    check("t1_busy_end", busy, 0);

    // 2. Glitch: high for 3 samples (edges 0..2).
    step(4);
    snap();
    button = 1'b1;
    step(2);                                   // after edge 1
    check("t2_busy0", busy, 0);
    step(1);                                   // after edge 2
    button = 1'b0;
    check("t2_busy1", busy, 1);
    step(2);                                   // after edge 4
    check("t2_busy3", busy, 1);
    step(1);                                   // after edge 5
    check("t2_busy_back", busy, 0);
    step(10);
    check("t2_roll", roll, 0);
    check("t2_pulses", (n_pressed - b_pressed) + (n_released - b_released), 0);

    // 3. Bouncy release with 1-cycle low blips.
    snap();
    button = 1'b1;
    step(8);
    check("t3_roll_up", roll, 1);
    step(2);
    for (int i = 0; i < 6; i++) begin
      button = 1'b0;
      step(1);
      check("t3_blip_lo", roll, 1);
      button = 1'b1;
      step(1);
      check("t3_blip_hi", roll, 1);
    end
    button = 1'b0;
    step(7);
    check("t3_roll_hold", roll, 1);
    check("t3_no_release", n_released - b_released, 0);
    step(1);
    check("t3_roll_fall", roll, 0);
    check("t3_released", released, 1);
    step(2);
    check("t3_release_count", n_released - b_released, 1);

    // 4. Shortest accepted tap: high for 5 samples (edges 0..4).
    step(4);
    snap();
    button = 1'b1;
    step(5);                                   // after edge 4
    button = 1'b0;
    step(3);                                   // after edge 7
    check("t4_roll", roll, 1);
    check("t4_pressed", pressed, 1);
    step(5);                                   // after edge 12
    check("t4_roll_min", roll, 1);
    step(1);                                   // after edge 13
    check("t4_roll_fall", roll, 0);
    check("t4_released", released, 1);
    check("t4_busy", busy, 0);
    step(2);
    check("t4_release_count", n_released - b_released, 1);

    // 5. Reset mid-roll (hcnt = 10 after edge 16), button kept high.
    step(4);
    button = 1'b1;
    step(17);                                  // after edge 16
    check("t5_roll_pre", roll, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t5_roll_rst", roll, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_pulses_rst", {pressed, released, long_press}, 0);
    step(7);
    check("t5_roll_redb", roll, 0);
    step(1);
    check("t5_roll_again", roll, 1);
    check("t5_pressed_again", pressed, 1);
    button = 1'b0;
    step(12);
    check("t5_idle", busy, 0);

    // 6. Dice chain: button high for 20 samples (edges 0..19) from dice = 1.
    dice_rst = 1'b1;
    step(1);
    dice_rst = 1'b0;
    step(2);
    check("t6_dice_start", dice, 1);
    button = 1'b1;
    step(7);                                   // after edge 6
    check("t6_dice_still", dice, 1);
    step(7);                                   // after edge 13: 6 advances
    check("t6_dice_wrap", dice, 1);
    step(6);                                   // after edge 19
    button = 1'b0;
    step(7);                                   // after edge 26
    check("t6_roll_hold", roll, 1);
    step(1);                                   // after edge 27: 20 advances
    check("t6_roll_fall", roll, 0);
    check("t6_dice_final", dice, 3);
    step(8);
    check("t6_dice_stable", dice, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
